ctrl_linha_engarrafamento: RTL and testbench
============================================

Name: ctrl_linha_engarrafamento

Overview:
Supervisory controller for the bottling line's production FSM (enchimento/vedação). It owns the cork (rolha) stock counter and drives the RO sensor input of the production FSM. It commands the cork dispenser refill, counts produced bottles into batches (dúzias), and gates the line through start/stop and packing pauses. The production FSM sits below it; its GP output feeds this block.

Parameters:
STOCK_MAX, 15, cork reservoir capacity; stock saturates here.
REFILL_LEVEL, 5, dispenser is requested while stock <= this value.
BATCH_SIZE, 12, bottles per batch (one dúzia).
PAUSE_CYC, 4, clock cycles the line is held in PAUSA after each completed batch.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low
start  in  1  start button, level; acted on at its rising edge
stop  in  1  stop button, level; acted on at its rising edge
gp  in  1  bottle-produced level from the production FSM; one bottle per rising edge
disp_vazio  in  1  1 = dispenser empty, no corks can be fed
carga_manual  in  1  manual cork load; +1 cork per rising edge
ro  out  1  1 = stock > 0; drives the RO input of the production FSM
run_en  out  1  1 = line enabled (gates the conveyor/production FSM)
disp_en  out  1  1 = dispenser releasing one cork this cycle
alarme  out  1  1 = out of corks with dispenser empty
stock  out  4  current cork count, 0..STOCK_MAX
lote_cnt  out  4  bottles in the current batch, 0..BATCH_SIZE-1
duzias  out  8  completed batches, wraps 255->0
state  out  2  current supervisor state

Behaviour:
- Reset (reset=0, async): state=PARADO, stock=STOCK_MAX, lote_cnt=0, duzias=0, pause counter=0, all edge-detect registers=0. All 1-bit outputs are 0 except ro=1.
- Edge detection: start, stop, gp and carga_manual are each registered once. An event is in=1 & prev=0, so it is seen in the same cycle the input rises. A level held high produces exactly one event.
- States: PARADO=0, OPERANDO=1, PAUSA=2, ALARME=3.
- PARADO: run_en=0. On a start event, go to OPERANDO if stock>0. On a start event with stock==0, go to ALARME.
- OPERANDO: run_en=1. Checks run in this priority order:
  - stop event -> PARADO.
  - stock==0 & disp_vazio -> ALARME.
  - batch completion (gp event with lote_cnt==BATCH_SIZE-1) -> PAUSA, pause counter loaded with PAUSE_CYC-1.
- PAUSA: run_en=0. Pause counter decrements each cycle; at 0, go to OPERANDO. A stop event goes to PARADO and overrides the pause.
- ALARME: run_en=0, alarme=1. A start event with stock>0 -> OPERANDO. A stop event -> PARADO.
- Stock update, registered, evaluated every cycle in every state:
  - dec = gp event & stock>0.
  - inc = disp_en | (carga_manual event).
  - stock_next = stock - dec + inc, saturated to 0..STOCK_MAX.
  - When dec and inc occur together, the net change is 0 (or the saturated result).
  - Manual load and dispenser in the same cycle count as +1 only.
- disp_en is a registered output. It is set for the next cycle when all hold: stock_next <= REFILL_LEVEL, stock_next < STOCK_MAX, disp_vazio=0, state != ALARME.
- Once disp_en is set, it stays asserted each cycle until stock reaches STOCK_MAX or disp_vazio=1 (hysteresis: refill runs all the way to full).
- A gp event when stock==0 leaves stock at 0 and is still counted as a bottle (fault tolerance).
- Batch counting: a gp event increments lote_cnt in any state. At BATCH_SIZE-1 it wraps to 0 and duzias increments, wrapping 255->0.
- ro = (stock != 0), combinational from the register, so it changes the cycle after the stock update.
- A reset in any state or mid-pause returns all of the above to reset values immediately.

Decomposition:
- Package: state encoding constants (PARADO/OPERANDO/PAUSA/ALARME) and the default values of STOCK_MAX, REFILL_LEVEL, BATCH_SIZE, PAUSE_CYC.
- Sub-module: detector_borda, a 1-bit rising-edge detector (clk, reset, in -> pulse). Instantiate it four times (start, stop, gp, carga_manual).

Test Plan:
- Reset, then a start pulse -> state=1 and run_en=1 next cycle; stock=15, ro=1, disp_en=0.
- 10 gp rising edges with disp_vazio=0 -> stock reaches 5, disp_en asserts the following cycle, and the refill returns stock to 15 even while gp continues; verify the net-0 cycle when gp and disp_en coincide.
- 12 gp edges from lote_cnt=0 -> lote_cnt wraps to 0, duzias=1, state=2 with run_en=0 for exactly 4 cycles, then state=1.
- disp_vazio=1, 15 gp edges -> stock=0, ro=0, state=3, alarme=1.
  - A start event now keeps state=3.
  - One carga_manual edge gives stock=1; a following start event -> state=1.
- Stop during PAUSA -> state=0 next cycle. Reset asserted mid-refill -> disp_en=0, stock=15, lote_cnt=0 asynchronously.
- gp held high for 20 cycles -> exactly one decrement and one lote_cnt increment.

Source files
------------

// File: rtl/ctrl_linha_engarrafamento_pkg.sv
// Shared definitions for the bottling-line supervisor.
// Contents:
//   estado_t          - supervisor state encoding (PARADO/OPERANDO/PAUSA/ALARME)
//   *_DEF localparams - default cork capacity, refill threshold, batch size
//                       and post-batch pause length
package ctrl_linha_engarrafamento_pkg;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    OPERANDO = 2'd1,
    PAUSA    = 2'd2,
    ALARME   = 2'd3
  } estado_t;

  localparam int STOCK_MAX_DEF    = 15;
  localparam int REFILL_LEVEL_DEF = 5;
  localparam int BATCH_SIZE_DEF   = 12;
  localparam int PAUSE_CYC_DEF    = 4;

endpackage

// File: rtl/ctrl_linha_engarrafamento_detector_borda.sv
// 1-bit rising-edge detector.
// Ports:
//   clk     - system clock
//   reset   - asynchronous, active-low
//   in_i    - level input
//   pulse_o - high while in_i=1 and the registered copy is still 0, so the
//             event is visible in the same cycle the input rises and a held
//             level yields exactly one pulse
module detector_borda (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic pulse_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= in_i;
    end
  end

  assign pulse_o = in_i & ~prev_q;

endmodule

// File: rtl/ctrl_linha_engarrafamento.sv
// Supervisory controller for the bottling line. Owns the cork stock counter,
// drives the RO input of the production FSM, commands dispenser refills,
// counts bottles into batches and gates the line (start/stop, batch pauses).
// Ports:
//   clk, reset          - clock; asynchronous active-low reset
//   start, stop         - buttons, acted on at their rising edge
//   gp                  - bottle produced (one bottle per rising edge)
//   disp_vazio          - dispenser empty
//   carga_manual        - manual cork load, +1 per rising edge
//   ro                  - stock > 0
//   run_en              - line enabled (OPERANDO only)
//   disp_en             - dispenser releases one cork this cycle (registered)
//   alarme              - out of corks with dispenser empty
//   stock, lote_cnt     - cork count, bottles in current batch
//   duzias              - completed batches (wraps)
//   state               - current supervisor state
module ctrl_linha_engarrafamento
  import ctrl_linha_engarrafamento_pkg::*;
#(
  parameter int STOCK_MAX    = STOCK_MAX_DEF,
  parameter int REFILL_LEVEL = REFILL_LEVEL_DEF,
  parameter int BATCH_SIZE   = BATCH_SIZE_DEF,
  parameter int PAUSE_CYC    = PAUSE_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       gp,
  input  logic       disp_vazio,
  input  logic       carga_manual,
  output logic       ro,
  output logic       run_en,
  output logic       disp_en,
  output logic       alarme,
  output logic [3:0] stock,
  output logic [3:0] lote_cnt,
  output logic [7:0] duzias,
  output logic [1:0] state
);

  localparam logic [3:0] STOCK_MAX_W  = 4'(STOCK_MAX);
  localparam logic [3:0] REFILL_W     = 4'(REFILL_LEVEL);
  localparam logic [3:0] BATCH_LAST_W = 4'(BATCH_SIZE - 1);
  localparam logic [3:0] PAUSE_LOAD_W = 4'(PAUSE_CYC - 1);

  // Bit order: 0=start, 1=stop, 2=gp, 3=carga_manual
  logic [3:0] btn_raw;
  logic [3:0] btn_ev;
  logic       start_ev, stop_ev, gp_ev, carga_ev;

  assign btn_raw = {carga_manual, gp, stop, start};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_borda
      detector_borda u_det (
        .clk     (clk),
        .reset   (reset),
        .in_i    (btn_raw[gi]),
        .pulse_o (btn_ev[gi])
      );
    end
  endgenerate

  assign start_ev = btn_ev[0];
  assign stop_ev  = btn_ev[1];
  assign gp_ev    = btn_ev[2];
  assign carga_ev = btn_ev[3];

  estado_t    state_q, state_d;
  logic [3:0] stock_q, stock_d;
  logic [3:0] lote_q, lote_d;
  logic [7:0] duzias_q, duzias_d;
  logic [3:0] pause_q, pause_d;
  logic       disp_en_q, disp_en_d;

  logic       dec, inc, batch_done;
  logic [4:0] stock_sum;

  // Stock, refill request and batch counting
  always_comb begin
    // A bottle with no cork in stock still counts, but stock stays at 0.
    dec        = gp_ev && (stock_q != 4'd0);
    // Manual load and dispenser together add only one cork.
    inc        = disp_en_q || carga_ev;
    stock_sum  = {1'b0, stock_q} + {4'd0, inc} - {4'd0, dec};
    stock_d    = (stock_sum > {1'b0, STOCK_MAX_W}) ? STOCK_MAX_W : stock_sum[3:0];

    // Start refilling at the low-water mark, then keep going until full
    // (or the dispenser runs dry).
    disp_en_d  = !disp_vazio && (stock_d < STOCK_MAX_W) &&
                 (disp_en_q || ((stock_d <= REFILL_W) && (state_q != ALARME)));

    batch_done = gp_ev && (lote_q == BATCH_LAST_W);
    lote_d     = lote_q;
    duzias_d   = duzias_q;
    if (gp_ev) begin
      if (batch_done) begin
        lote_d   = 4'd0;
        duzias_d = duzias_q + 8'd1;
      end else begin
        lote_d   = lote_q + 4'd1;
      end
    end
  end

  // Supervisor next-state
  always_comb begin
    state_d = state_q;
    pause_d = pause_q;
    case (state_q)
      PARADO: begin
        if (start_ev) begin
          state_d = (stock_q != 4'd0) ? OPERANDO : ALARME;
        end
      end
      OPERANDO: begin
        if (stop_ev) begin
          state_d = PARADO;
        end else if ((stock_q == 4'd0) && disp_vazio) begin
          state_d = ALARME;
        end else if (batch_done) begin
          state_d = PAUSA;
          pause_d = PAUSE_LOAD_W;
        end
      end
      PAUSA: begin
        if (stop_ev) begin
          state_d = PARADO;
        end else if (pause_q == 4'd0) begin
          state_d = OPERANDO;
        end else begin
          pause_d = pause_q - 4'd1;
        end
      end
      ALARME: begin
        if (start_ev && (stock_q != 4'd0)) begin
          state_d = OPERANDO;
        end else if (stop_ev) begin
          state_d = PARADO;
        end
      end
      default: state_d = PARADO;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= PARADO;
      stock_q   <= STOCK_MAX_W;
      lote_q    <= 4'd0;
      duzias_q  <= 8'd0;
      pause_q   <= 4'd0;
      disp_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stock_q   <= stock_d;
      lote_q    <= lote_d;
      duzias_q  <= duzias_d;
      pause_q   <= pause_d;
      disp_en_q <= disp_en_d;
    end
  end

  assign ro       = (stock_q != 4'd0);
  assign run_en   = (state_q == OPERANDO);
  assign alarme   = (state_q == ALARME);
  assign disp_en  = disp_en_q;
  assign stock    = stock_q;
  assign lote_cnt = lote_q;
  assign duzias   = duzias_q;
  assign state    = state_q;

endmodule

// File: tb/tb_ctrl_linha_engarrafamento.sv
module tb_ctrl_linha_engarrafamento;

  localparam int SMAX   = 15;
  localparam int REFILL = 5;
  localparam int BATCH  = 12;
  localparam int PAUSE  = 4;

  logic       clk, reset, start, stop, gp, disp_vazio, carga_manual;
  logic       ro, run_en, disp_en, alarme;
  logic [3:0] stock, lote_cnt;
  logic [7:0] duzias;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  ctrl_linha_engarrafamento dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .gp           (gp),
    .disp_vazio   (disp_vazio),
    .carga_manual (carga_manual),
    .ro           (ro),
    .run_en       (run_en),
    .disp_en      (disp_en),
    .alarme       (alarme),
    .stock        (stock),
    .lote_cnt     (lote_cnt),
    .duzias       (duzias),
    .state        (state)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Behavioural model: plain integers, stepped once per clock from the rules.
  typedef struct packed {
    int stock;
    int lote;
    int duz;
    int st;      // 0 stopped, 1 running, 2 pause, 3 alarm
    int pause_left;
    bit disp;
    bit p_start;
    bit p_stop;
    bit p_gp;
    bit p_cm;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.stock = SMAX;
    return r;
  endfunction

  function automatic model_t model_step(model_t c, bit st, bit sp, bit g, bit dv, bit cm);
    model_t n = c;
    bit s_ev = st && !c.p_start;
    bit p_ev = sp && !c.p_stop;
    bit g_ev = g && !c.p_gp;
    bit c_ev = cm && !c.p_cm;
    bool_done: begin end
    n.stock = c.stock + ((c.disp || c_ev) ? 1 : 0) - ((g_ev && c.stock > 0) ? 1 : 0);
    if (n.stock > SMAX) n.stock = SMAX;
    if (n.stock < 0) n.stock = 0;
    n.disp = !dv && (n.stock < SMAX) && (c.disp || (n.stock <= REFILL && c.st != 3));
    if (g_ev) begin
      n.lote = (c.lote + 1) % BATCH;
      if (n.lote == 0) n.duz = (c.duz + 1) % 256;
    end
    if (c.st == 0) begin
      if (s_ev) n.st = (c.stock > 0) ? 1 : 3;
    end else if (c.st == 1) begin
      if (p_ev) n.st = 0;
      else if (c.stock == 0 && dv) n.st = 3;
      else if (g_ev && c.lote == BATCH - 1) begin
        n.st = 2;
        n.pause_left = PAUSE - 1;
      end
    end else if (c.st == 2) begin
      if (p_ev) n.st = 0;
      else if (c.pause_left == 0) n.st = 1;
      else n.pause_left = c.pause_left - 1;
    end else begin
      if (s_ev && c.stock > 0) n.st = 1;
      else if (p_ev) n.st = 0;
    end
    n.p_start = st;
    n.p_stop  = sp;
    n.p_gp    = g;
    n.p_cm    = cm;
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= model_reset();
    else        m <= model_step(m, start, stop, gp, disp_vazio, carga_manual);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_state",   int'(state),    m.st);
      check("m_stock",   int'(stock),    m.stock);
      check("m_lote",    int'(lote_cnt), m.lote);
      check("m_duzias",  int'(duzias),   m.duz);
      check("m_disp_en", int'(disp_en),  int'(m.disp));
      check("m_ro",      int'(ro),       (m.stock != 0) ? 1 : 0);
      check("m_run_en",  int'(run_en),   (m.st == 1) ? 1 : 0);
      check("m_alarme",  int'(alarme),   (m.st == 3) ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic gp_pulse();
    gp = 1; step();
    gp = 0; step();
  endtask

  int cnt;

  initial begin
    reset = 0; start = 0; stop = 0; gp = 0; disp_vazio = 0; carga_manual = 0;
    repeat (3) step();
    check("rst_stock", int'(stock), 15);
    check("rst_ro", int'(ro), 1);
    check("rst_state", int'(state), 0);
    check("rst_disp_en", int'(disp_en), 0);
    check("rst_lote", int'(lote_cnt), 0);
    cmp_en = 1;
    reset = 1;
    step();

    // Start
    start = 1; step();
    check("start_state", int'(state), 1);
    check("start_run_en", int'(run_en), 1);
    check("start_stock", int'(stock), 15);
    check("start_disp_en", int'(disp_en), 0);
    start = 0; step();

    // 10 bottles: stock down to the refill mark
    repeat (9) gp_pulse();
    gp = 1; step();
    check("refill_stock5", int'(stock), 5);
    check("refill_disp_on", int'(disp_en), 1);
    gp = 0; step();
    gp = 1; step();
    check("net0_stock", int'(stock), 6);
    check("net0_lote", int'(lote_cnt), 11);
    gp = 0; step();
    repeat (10) step();
    check("refill_full", int'(stock), 15);
    check("refill_disp_off", int'(disp_en), 0);

    // Batch completion and pause length
    gp = 1; step();
    check("batch_state", int'(state), 2);
    check("batch_lote", int'(lote_cnt), 0);
    check("batch_duzias", int'(duzias), 1);
    check("batch_run_en", int'(run_en), 0);
    gp = 0;
    cnt = 0;
    for (int k = 0; k < 20 && state == 2'd2; k++) begin
      cnt++;
      step();
    end
    check("pause_cycles", cnt, 4);
    check("pause_exit_state", int'(state), 1);

    // Run out of corks with dispenser empty
    disp_vazio = 1;
    repeat (15) gp_pulse();
    repeat (2) step();
    check("alarm_stock", int'(stock), 0);
    check("alarm_ro", int'(ro), 0);
    check("alarm_state", int'(state), 3);
    check("alarm_alarme", int'(alarme), 1);
    start = 1; step(); start = 0; step();
    check("alarm_start_hold", int'(state), 3);
    carga_manual = 1; step();
    check("manual_stock", int'(stock), 1);
    carga_manual = 0; step();
    start = 1; step();
    check("alarm_recover", int'(state), 1);
    start = 0; step();

    // Refill, then stop during a pause
    disp_vazio = 0;
    repeat (20) step();
    check("refill2_full", int'(stock), 15);
    repeat (9) gp_pulse();
    check("pause2_state", int'(state), 2);
    stop = 1; step();
    check("stop_in_pause", int'(state), 0);
    stop = 0; step();

    // Reset while refilling
    repeat (2) gp_pulse();
    check("midrefill_disp", int'(disp_en), 1);
    reset = 0;
    #1;
    check("arst_disp_en", int'(disp_en), 0);
    check("arst_stock", int'(stock), 15);
    check("arst_lote", int'(lote_cnt), 0);
    check("arst_state", int'(state), 0);
    step();
    reset = 1;
    step();

    // gp held high: one bottle only
    start = 1; step(); start = 0; step();
    gp = 1;
    repeat (20) step();
    gp = 0; step();
    check("held_gp_stock", int'(stock), 14);
    check("held_gp_lote", int'(lote_cnt), 1);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      start        = ($urandom_range(0, 14) == 0);
      stop         = ($urandom_range(0, 39) == 0);
      gp           = ($urandom_range(0, 1) == 1);
      carga_manual = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 59) == 0) disp_vazio = ~disp_vazio;
      if ($urandom_range(0, 299) == 0) begin
        reset = 0; step(); reset = 1;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
